// File: rtl/vga_pixel_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : vga_pixel_fifo_if
// Desc     : Frame-start, memory read port, pop request and pixel/status
//            outputs of vga_pixel_fifo. oUNDERFLOW_CNT exists only when
//            PIXEL_FIFO_STATS_EN is defined.
// Revision : 1.0
// ============================================================================
interface vga_pixel_fifo_if #(
  parameter int DEPTH = 512
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic          iFRAME_START;
  logic          oRD_REQ;
  logic [21:0]   oRD_ADDR;
  logic          iRD_ACK;
  logic          iRD_VALID;
  logic [29:0]   iRD_DATA;
  logic          iRequest;
  logic [9:0]    oRed;
  logic [9:0]    oGreen;
  logic [9:0]    oBlue;
  logic [LW-1:0] oLEVEL;
  logic          oUNDERFLOW;
`ifdef PIXEL_FIFO_STATS_EN
  logic [15:0]   oUNDERFLOW_CNT;
`endif

  // Driver side: frame timing, memory responder and VGA controller.
  modport master (
`ifdef PIXEL_FIFO_STATS_EN
    input  oUNDERFLOW_CNT,
`endif
    output iFRAME_START, iRD_ACK, iRD_VALID, iRD_DATA, iRequest,
    input  oRD_REQ, oRD_ADDR, oRed, oGreen, oBlue, oLEVEL, oUNDERFLOW
  );

  // Pixel FIFO side.
  modport slave (
`ifdef PIXEL_FIFO_STATS_EN
    output oUNDERFLOW_CNT,
`endif
    input  iFRAME_START, iRD_ACK, iRD_VALID, iRD_DATA, iRequest,
    output oRD_REQ, oRD_ADDR, oRed, oGreen, oBlue, oLEVEL, oUNDERFLOW
  );
endinterface
`default_nettype wire

// File: rtl/vga_pixel_fifo.sv
`default_nettype none
// ============================================================================
// Module   : vga_pixel_fifo
// Desc     : Burst-prefetch pixel FIFO upstream of the VGA timing controller.
//            Define PIXEL_FIFO_STATS_EN to add the oUNDERFLOW_CNT counter.
// Revision : 1.0
// ============================================================================
module vga_pixel_fifo #(
  parameter int DEPTH        = 512,
  parameter int BURST        = 256,
  parameter int FRAME_PIXELS = 307200
) (
  input wire              iCLK,
  input wire              iRST,
  vga_pixel_fifo_if.slave bus
);
  localparam int AW  = $clog2(DEPTH);
  localparam int LW  = AW + 1;
  localparam int BPF = FRAME_PIXELS / BURST;
  localparam int BCW = $clog2(BPF + 1);
  localparam int RW  = $clog2(BURST + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_FILL  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic           rd_req_q, rd_req_d;
  logic [21:0]    rd_addr_q, rd_addr_d;
  logic [BCW-1:0] burst_cnt_q, burst_cnt_d;
  logic [RW-1:0]  remain_q, remain_d;
  logic           flushed_q, flushed_d;
  logic [LW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [29:0]    pix_q, pix_d;
  logic           underflow_q, underflow_d;
`ifdef PIXEL_FIFO_STATS_EN
  logic [15:0]    uf_cnt_q, uf_cnt_d;
`endif

  logic [29:0]    mem [DEPTH];
  logic [LW-1:0]  level;
  logic           empty;
  logic           full;
  logic           flush;
  logic           wr_en;

  assign flush = bus.iFRAME_START;
  assign level = wr_ptr_q - rd_ptr_q;
  assign empty = (level == '0);
  assign full  = (level == LW'(DEPTH));

  always_comb begin
    state_d     = state_q;
    rd_req_d    = rd_req_q;
    rd_addr_d   = rd_addr_q;
    burst_cnt_d = burst_cnt_q;
    remain_d    = remain_q;
    flushed_d   = flushed_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    pix_d       = pix_q;
    underflow_d = underflow_q;
    wr_en       = 1'b0;
`ifdef PIXEL_FIFO_STATS_EN
    uf_cnt_d    = uf_cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (!flush && (burst_cnt_q < BCW'(BPF)) &&
            (level <= LW'(DEPTH - BURST))) begin
          state_d   = S_REQ;
          rd_req_d  = 1'b1;
          flushed_d = 1'b0;
        end
      end

      S_REQ: begin
        // A request is never withdrawn; a flush only redirects the burst.
        if (bus.iRD_ACK) begin
          rd_req_d  = 1'b0;
          remain_d  = RW'(BURST);
          state_d   = (flush || flushed_q) ? S_DRAIN : S_FILL;
          flushed_d = 1'b0;
        end else if (flush) begin
          flushed_d = 1'b1;
        end
      end

      S_FILL: begin
        if (bus.iRD_VALID) begin
          remain_d = remain_q - RW'(1);
          if (flush) begin
            state_d = (remain_q == RW'(1)) ? S_IDLE : S_DRAIN;
          end else begin
            wr_en = !full;
            if (remain_q == RW'(1)) begin
              state_d     = S_IDLE;
              rd_addr_d   = rd_addr_q + 22'(BURST);
              burst_cnt_d = burst_cnt_q + BCW'(1);
            end
          end
        end else if (flush) begin
          state_d = S_DRAIN;
        end
      end

      S_DRAIN: begin
        if (bus.iRD_VALID) begin
          remain_d = remain_q - RW'(1);
          if (remain_q == RW'(1)) begin
            state_d = S_IDLE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + LW'(1);
    end

    // Flush overrides any end-of-burst address/count update above.
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      rd_addr_d   = '0;
      burst_cnt_d = '0;
      underflow_d = 1'b0;
`ifdef PIXEL_FIFO_STATS_EN
      uf_cnt_d    = '0;
`endif
    end else if (bus.iRequest) begin
      if (!empty) begin
        pix_d    = mem[rd_ptr_q[AW-1:0]];
        rd_ptr_d = rd_ptr_q + LW'(1);
      end else begin
        pix_d       = '0;
        underflow_d = 1'b1;
`ifdef PIXEL_FIFO_STATS_EN
        if (uf_cnt_q != 16'hFFFF) begin
          uf_cnt_d = uf_cnt_q + 16'd1;
        end
`endif
      end
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q     <= S_IDLE;
      rd_req_q    <= 1'b0;
      rd_addr_q   <= '0;
      burst_cnt_q <= '0;
      remain_q    <= '0;
      flushed_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      pix_q       <= '0;
      underflow_q <= 1'b0;
`ifdef PIXEL_FIFO_STATS_EN
      uf_cnt_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rd_req_q    <= rd_req_d;
      rd_addr_q   <= rd_addr_d;
      burst_cnt_q <= burst_cnt_d;
      remain_q    <= remain_d;
      flushed_q   <= flushed_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      pix_q       <= pix_d;
      underflow_q <= underflow_d;
`ifdef PIXEL_FIFO_STATS_EN
      uf_cnt_q    <= uf_cnt_d;
`endif
    end
  end

  // Storage carries no reset; pointers alone define valid contents.
  always_ff @(posedge iCLK) begin
    if (wr_en) begin
      mem[wr_ptr_q[AW-1:0]] <= bus.iRD_DATA;
    end
  end

  assign bus.oRD_REQ    = rd_req_q;
  assign bus.oRD_ADDR   = rd_addr_q;
  assign bus.oRed       = pix_q[29:20];
  assign bus.oGreen     = pix_q[19:10];
  assign bus.oBlue      = pix_q[9:0];
  assign bus.oLEVEL     = level;
  assign bus.oUNDERFLOW = underflow_q;
`ifdef PIXEL_FIFO_STATS_EN
  assign bus.oUNDERFLOW_CNT = uf_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_pixel_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_pixel_fifo
// Desc     : Randomized bench for vga_pixel_fifo with a queue-based reference
//            model and pixel scoreboard. Honours PIXEL_FIFO_STATS_EN.
// Revision : 1.0
// ============================================================================
module tb_vga_pixel_fifo;
  localparam int DEPTH        = 16;
  localparam int BURST        = 4;
  localparam int FRAME_PIXELS = 32;
  localparam int BPF          = FRAME_PIXELS / BURST;

  logic clk = 1'b0;
  logic rst = 1'b1;

  vga_pixel_fifo_if #(.DEPTH(DEPTH)) bus ();

  vga_pixel_fifo #(
    .DEPTH       (DEPTH),
    .BURST       (BURST),
    .FRAME_PIXELS(FRAME_PIXELS)
  ) dut (
    .iCLK(clk),
    .iRST(rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: FIFO contents, frame position, sticky flags.
  logic [29:0] mdl_q[$];
  logic [29:0] sb_q[$];
  int          mdl_idx;
  bit          mdl_uf;
  int          mdl_cnt;

  // Memory responder state.
  bit req_open;
  bit req_stale;
  int ack_wait;
  int words_left;
  bit burst_live;
  bit ack_prev;
  int prev_size;
  int idle_run;

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_model();
    mdl_q.delete();
    sb_q.delete();
    mdl_idx    = 0;
    mdl_uf     = 1'b0;
    mdl_cnt    = 0;
    req_open   = 1'b0;
    req_stale  = 1'b0;
    ack_wait   = 0;
    words_left = 0;
    burst_live = 1'b0;
    ack_prev   = 1'b0;
    prev_size  = 0;
    idle_run   = 0;
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2;
    rst              = 1'b1;
    bus.iFRAME_START = 1'b0;
    bus.iRD_ACK      = 1'b0;
    bus.iRD_VALID    = 1'b0;
    bus.iRD_DATA     = '0;
    bus.iRequest     = 1'b0;
    #1;
    check("rst_req", bus.oRD_REQ, 0);
    check("rst_addr", bus.oRD_ADDR, 0);
    check("rst_pixel", {bus.oRed, bus.oGreen, bus.oBlue}, 0);
    check("rst_level", bus.oLEVEL, 0);
    check("rst_underflow", bus.oUNDERFLOW, 0);
`ifdef PIXEL_FIFO_STATS_EN
    check("rst_uf_cnt", bus.oUNDERFLOW_CNT, 0);
`endif
    clear_model();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock of stimulus: check state left by the previous edge, then pick
  // inputs for the next edge and advance the model accordingly.
  task automatic step(input int p_pop, input int p_flush, input bit hold);
    bit          flush;
    bit          valid;
    bit          ack;
    bit          pop;
    bit          in_burst;
    bit          was_full;
    logic [29:0] data;
    logic [29:0] exp;

    @(negedge clk);
    check("level", bus.oLEVEL, mdl_q.size());
    check("underflow", bus.oUNDERFLOW, mdl_uf);
`ifdef PIXEL_FIFO_STATS_EN
    check("uf_cnt", bus.oUNDERFLOW_CNT, mdl_cnt);
`endif
    if (ack_prev) begin
      check("req_drop", bus.oRD_REQ, 0);
    end else if (req_open) begin
      check("req_hold", bus.oRD_REQ, 1);
    end else if (bus.oRD_REQ) begin
      check("req_addr", bus.oRD_ADDR, (mdl_idx * BURST) % (1 << 22));
      check("req_budget", longint'(mdl_idx < BPF), 1);
      check("req_level", longint'(prev_size <= DEPTH - BURST), 1);
      check("req_overlap", words_left, 0);
      req_open  = 1'b1;
      req_stale = 1'b0;
      ack_wait  = $urandom_range(0, 3);
    end

    if (!bus.oRD_REQ && !req_open && words_left == 0 && mdl_idx < BPF &&
        mdl_q.size() <= DEPTH - BURST) begin
      idle_run++;
    end else begin
      idle_run = 0;
    end
    if (idle_run > 6) begin
      check("req_timeout", 0, 1);
      idle_run = 0;
    end
    prev_size = mdl_q.size();

    flush = ($urandom_range(0, 99) < p_flush);
    if (flush) begin
      idle_run = 0;
      if (req_open) req_stale = 1'b1;
      if (words_left > 0) burst_live = 1'b0;
    end

    data     = 30'($urandom());
    in_burst = (words_left > 0) && ($urandom_range(0, 3) != 0);
    valid    = in_burst || (!req_open && words_left == 0 && $urandom_range(0, 7) == 0);

    ack = 1'b0;
    if (req_open && !hold) begin
      if (ack_wait == 0) begin
        ack        = 1'b1;
        req_open   = 1'b0;
        words_left = BURST;
        burst_live = !req_stale;
      end else begin
        ack_wait--;
      end
    end

    pop      = ($urandom_range(0, 99) < p_pop);
    was_full = (mdl_q.size() >= DEPTH);
    if (flush) begin
      mdl_q.delete();
      mdl_idx = 0;
      mdl_uf  = 1'b0;
      mdl_cnt = 0;
    end else if (pop) begin
      if (mdl_q.size() > 0) begin
        exp = mdl_q.pop_front();
      end else begin
        exp    = '0;
        mdl_uf = 1'b1;
        if (mdl_cnt < 65535) mdl_cnt++;
      end
      sb_q.push_back(exp);
    end
    if (in_burst) begin
      words_left--;
      if (burst_live) begin
        if (!was_full) mdl_q.push_back(data);
        if (words_left == 0) mdl_idx++;
      end
    end

    bus.iFRAME_START = flush;
    bus.iRD_ACK      = ack;
    bus.iRD_VALID    = valid;
    bus.iRD_DATA     = data;
    bus.iRequest     = pop;
    ack_prev         = ack;
  endtask

  // Monitor: every accepted pop must show the scoreboard's next pixel.
  initial begin
    bit          popped;
    logic [29:0] exp;
    forever begin
      @(posedge clk);
      popped = bus.iRequest && !bus.iFRAME_START && !rst;
      #2;
      if (popped) begin
        if (sb_q.size() == 0) begin
          check("sb_underrun", 1, 0);
        end else begin
          exp = sb_q.pop_front();
          check("pixel", {bus.oRed, bus.oGreen, bus.oBlue}, exp);
        end
      end
    end
  end

  initial begin
    bus.iFRAME_START = 1'b0;
    bus.iRD_ACK      = 1'b0;
    bus.iRD_VALID    = 1'b0;
    bus.iRD_DATA     = '0;
    bus.iRequest     = 1'b0;
    clear_model();
    async_reset();

    // Fill with no pops; requests must stop once the level is too high.
    repeat (60) step(0, 0, 1'b0);
    // Mixed traffic with occasional frame starts.
    repeat (1500) step(50, 2, 1'b0);
    // Starve the FIFO: no new bursts accepted, pop every cycle.
    repeat (80) step(100, 0, 1'b1);
    check("uf_sticky", bus.oUNDERFLOW, 1);
    step(0, 100, 1'b0);
    repeat (20) step(0, 0, 1'b0);
    // Whole frame: prefill, then steady pops; no request past the last burst.
    step(0, 100, 1'b0);
    repeat (30) step(0, 0, 1'b0);
    repeat (400) step(40, 0, 1'b0);
    // Asynchronous reset in the middle of traffic.
    repeat (37) step(50, 0, 1'b0);
    async_reset();
    // Frequent flushes to land in REQ, FILL and DRAIN.
    repeat (600) step(60, 10, 1'b0);
    repeat (40) step(0, 0, 1'b0);

    @(negedge clk);
    check("sb_drain", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
